// File: rtl/mig_cmd_queue.sv
// mig_cmd_queue: round-robin write/read command arbiter feeding a FWFT command queue for the MIG sequencer
module mig_cmd_queue #(
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 8,
  parameter int AW       = 3,
  parameter int AFULL_TH = 2**AW-2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wcmd_valid,
  output logic              wcmd_ready,
  input  logic [ADDR_W-1:0] wcmd_addr,
  input  logic [LEN_W-1:0]  wcmd_len,
  input  logic              rcmd_valid,
  output logic              rcmd_ready,
  input  logic [ADDR_W-1:0] rcmd_addr,
  input  logic [LEN_W-1:0]  rcmd_len,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [ADDR_W-1:0] q_addr,
  output logic [LEN_W-1:0]  q_len,
  output logic              q_rd,
  output logic [AW:0]       q_count,
  output logic              q_empty,
  output logic              q_afull
);
  localparam int EW = 1 + LEN_W + ADDR_W;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_TH);
  logic [EW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_prio_rd;
  logic          w_ok, w_push_r, w_push, w_pop;
  logic [EW-1:0] w_entry, w_head;
  always_comb begin
    w_ok       = ~rst & (r_count != DEPTH_C);
    rcmd_ready = w_ok & (~wcmd_valid | r_prio_rd);
    wcmd_ready = w_ok & (~rcmd_valid | ~r_prio_rd);
    w_push_r   = rcmd_valid & rcmd_ready;
    w_push     = w_push_r | (wcmd_valid & wcmd_ready);
    w_pop      = q_valid & q_ready;
    w_entry    = w_push_r ? {1'b1, rcmd_len, rcmd_addr} : {1'b0, wcmd_len, wcmd_addr};
    w_head     = q_valid ? r_mem[r_rptr] : '0;
  end
  assign q_count = r_count;
  assign q_empty = r_count == '0;
  assign q_valid = ~q_empty;
  assign q_afull = r_count >= AFULL_C;
  assign {q_rd, q_len, q_addr} = w_head;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= w_entry;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_prio_rd <= 1'b1;
    end else begin
      if (w_push) begin
        r_wptr    <= r_wptr + 1'b1;
        r_prio_rd <= ~w_push_r;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule
